// File: rtl/pipe_control.sv
// pipe_control: instruction decode and EX/MEM/WB control pipeline for a small
// LEGv8-style core. ID-stage branch controls are combinational. EX, MEM and WB
// controls are registered and carry a valid bit per stage. Also holds the NZVC
// flag register and a sticky illegal-instruction flag.
module pipe_control #(
   parameter int unsigned ALUOP_W        = 3,
   parameter bit          FLAG_FWD       = 1'b1,
   parameter bit          NOP_ON_ILLEGAL = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        instr,
   input  logic               instr_valid,
   input  logic               stall,
   input  logic               flush,
   input  logic               rd_zero,
   input  logic               alu_zero,
   input  logic               alu_negative,
   input  logic               alu_overflow,
   input  logic               alu_carry,
   output logic               id_Reg2Loc,
   output logic               id_UncondBr,
   output logic               br_taken,
   output logic               ex_ALUSrc,
   output logic               ex_ShiftSel,
   output logic               ex_SetFlags,
   output logic [ALUOP_W-1:0] ex_ALUOp,
   output logic               mem_MemWrite,
   output logic               mem_MemRead,
   output logic               wb_RegWrite,
   output logic               wb_MemToReg,
   output logic [3:0]         flags,
   output logic               illegal
);

   logic [10:0] op;
   logic is_addi, is_adds, is_subs, is_and, is_eor, is_lsr, is_ldur, is_stur;
   logic is_b, is_cbz, is_blt, legal, is_rtype;
   logic dec_alusrc, dec_shiftsel, dec_setflags, dec_memwrite, dec_memread;
   logic dec_regwrite, dec_memtoreg;
   logic [2:0] dec_aluop;
   logic [ALUOP_W-1:0] dec_aluop_ext;
   logic ex_load, flag_n, flag_v;

   logic ex_valid_q, ex_alusrc_q, ex_shiftsel_q, ex_setflags_q;
   logic ex_memwrite_q, ex_memread_q, ex_regwrite_q, ex_memtoreg_q;
   logic [ALUOP_W-1:0] ex_aluop_q;
   logic mem_valid_q, mem_memwrite_q, mem_memread_q, mem_regwrite_q, mem_memtoreg_q;
   logic wb_valid_q, wb_regwrite_q, wb_memtoreg_q;
   logic [3:0] flags_q;
   logic illegal_q;

   // Register/immediate fields are consumed by the datapath, not by control.
   logic unused_instr;
   assign unused_instr = ^instr[20:5];

   // Opcode match and per-instruction control decode; anything unmatched decodes to zeros.
   always_comb begin
      op       = instr[31:21];
      is_addi  = (op[10:1] == 10'b1001000100);
      is_adds  = (op == 11'b10101011000);
      is_subs  = (op == 11'b11101011000);
      is_and   = (op == 11'b10001010000);
      is_eor   = (op == 11'b11001010000);
      is_lsr   = (op == 11'b11010011010);
      is_ldur  = (op == 11'b11111000010);
      is_stur  = (op == 11'b11111000000);
      is_b     = (op[10:5] == 6'b000101);
      is_cbz   = (op[10:3] == 8'b10110100);
      is_blt   = (op[10:3] == 8'b01010100) && (instr[4:0] == 5'b01011);
      legal    = is_addi | is_adds | is_subs | is_and | is_eor | is_lsr | is_ldur | is_stur |
                 is_b | is_cbz | is_blt;
      is_rtype = is_adds | is_subs | is_and | is_eor | is_lsr;

      dec_alusrc   = is_addi | is_ldur | is_stur | is_lsr;
      dec_shiftsel = is_lsr;
      dec_setflags = is_adds | is_subs;
      dec_memwrite = is_stur;
      dec_memread  = is_ldur;
      dec_memtoreg = is_ldur;
      dec_regwrite = is_addi | is_adds | is_subs | is_and | is_eor | is_lsr | is_ldur;
      dec_aluop    = 3'b000;
      if (is_addi | is_adds | is_ldur | is_stur) dec_aluop = 3'b010;
      if (is_subs)                               dec_aluop = 3'b011;
      if (is_and)                                dec_aluop = 3'b100;
      if (is_eor)                                dec_aluop = 3'b110;
      dec_aluop_ext      = '0;
      dec_aluop_ext[2:0] = dec_aluop;
   end

   // Without NOP_ON_ILLEGAL an illegal op still occupies EX, but with all-zero controls.
   assign ex_load = instr_valid & ~stall & ~flush & (legal | ~NOP_ON_ILLEGAL);

   // B.LT condition source: live ALU flags when a flag-setting op sits in EX.
   always_comb begin
      flag_n = flags_q[3];
      flag_v = flags_q[1];
      if (FLAG_FWD && ex_SetFlags) begin
         flag_n = alu_negative;
         flag_v = alu_overflow;
      end
   end

   assign id_Reg2Loc  = instr_valid & is_rtype;
   assign id_UncondBr = instr_valid & is_b;
   assign br_taken    = ~reset & instr_valid & ~stall & ~flush &
                        (is_b | (is_cbz & rd_zero) | (is_blt & (flag_n != flag_v)));

   // Pipeline registers, flag register and sticky illegal flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid_q     <= 1'b0;
         ex_alusrc_q    <= 1'b0;
         ex_shiftsel_q  <= 1'b0;
         ex_setflags_q  <= 1'b0;
         ex_aluop_q     <= '0;
         ex_memwrite_q  <= 1'b0;
         ex_memread_q   <= 1'b0;
         ex_regwrite_q  <= 1'b0;
         ex_memtoreg_q  <= 1'b0;
         mem_valid_q    <= 1'b0;
         mem_memwrite_q <= 1'b0;
         mem_memread_q  <= 1'b0;
         mem_regwrite_q <= 1'b0;
         mem_memtoreg_q <= 1'b0;
         wb_valid_q     <= 1'b0;
         wb_regwrite_q  <= 1'b0;
         wb_memtoreg_q  <= 1'b0;
         flags_q        <= 4'b0000;
         illegal_q      <= 1'b0;
      end else begin
         ex_valid_q     <= ex_load;
         ex_alusrc_q    <= ex_load & dec_alusrc;
         ex_shiftsel_q  <= ex_load & dec_shiftsel;
         ex_setflags_q  <= ex_load & dec_setflags;
         ex_aluop_q     <= ex_load ? dec_aluop_ext : '0;
         ex_memwrite_q  <= ex_load & dec_memwrite;
         ex_memread_q   <= ex_load & dec_memread;
         ex_regwrite_q  <= ex_load & dec_regwrite;
         ex_memtoreg_q  <= ex_load & dec_memtoreg;
         mem_valid_q    <= ex_valid_q;
         mem_memwrite_q <= ex_valid_q & ex_memwrite_q;
         mem_memread_q  <= ex_valid_q & ex_memread_q;
         mem_regwrite_q <= ex_valid_q & ex_regwrite_q;
         mem_memtoreg_q <= ex_valid_q & ex_memtoreg_q;
         wb_valid_q     <= mem_valid_q;
         wb_regwrite_q  <= mem_valid_q & mem_regwrite_q;
         wb_memtoreg_q  <= mem_valid_q & mem_memtoreg_q;
         if (ex_SetFlags) begin
            flags_q <= {alu_negative, alu_zero, alu_overflow, alu_carry};
         end
         // A flushed slot never executed, so it cannot raise illegal.
         if (instr_valid & ~flush & ~legal) begin
            illegal_q <= 1'b1;
         end
      end
   end

   assign ex_ALUSrc    = ex_valid_q & ex_alusrc_q;
   assign ex_ShiftSel  = ex_valid_q & ex_shiftsel_q;
   assign ex_SetFlags  = ex_valid_q & ex_setflags_q;
   assign ex_ALUOp     = ex_valid_q ? ex_aluop_q : '0;
   assign mem_MemWrite = mem_valid_q & mem_memwrite_q;
   assign mem_MemRead  = mem_valid_q & mem_memread_q;
   assign wb_RegWrite  = wb_valid_q & wb_regwrite_q;
   assign wb_MemToReg  = wb_valid_q & wb_memtoreg_q;
   assign flags        = flags_q;
   assign illegal      = illegal_q;

endmodule

// File: doc/pipe_control.md
PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 SHALL have parameter ALUOP_W, default 3, width of the ALU operation code.
REQ-002 SHALL have parameter FLAG_FWD, default 1, 1 = B.LT in ID uses live EX-stage ALU flags when EX sets flags; 0 = uses only the flag register.
REQ-003 SHALL have parameter NOP_ON_ILLEGAL, default 1, 1 = undecodable instruction becomes bubble; 0 = decoded as bubble plus sticky illegal flag only.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 instr  in  32  instruction in ID stage.
REQ-007 instr_valid  in  1  instr holds a real instruction.
REQ-008 stall  in  1  hazard unit: hold ID, inject bubble into EX.
REQ-009 flush  in  1  kill ID-stage instruction (bubble into EX).
REQ-010 rd_zero  in  1  register read for CBZ equals zero (ID stage).
REQ-011 alu_zero, alu_negative, alu_overflow, alu_carry  in  1 each  EX-stage ALU flags.
REQ-012 id_Reg2Loc, id_UncondBr, br_taken  out  1 each  ID-stage controls (combinational).
REQ-013 ex_ALUSrc, ex_ShiftSel, ex_SetFlags  out  1 each; ex_ALUOp  out  ALUOP_W.
REQ-014 mem_MemWrite, mem_MemRead  out  1 each; wb_RegWrite, wb_MemToReg  out  1 each.
REQ-015 flags  out  4  registered {N,Z,V,C}; illegal  out  1  sticky.

Function
REQ-016 Decode from instr[31:21]: ADDI 1001000100x, ADDS 10101011000, SUBS 11101011000, AND 10001010000, EOR 11001010000, LSR 11010011010, LDUR 11111000010, STUR 11111000000, B 000101xxxxx, CBZ 10110100xxx, B.LT 01010100xxx with instr[4:0]=01011.
REQ-017 ALUOp: 000 pass-B (CBZ), 010 add (ADDI, ADDS, LDUR, STUR), 011 sub (SUBS), 100 and, 110 xor; LSR drives ShiftSel=1, ALUOp=000; upper bits zero-extended when ALUOP_W>3.
REQ-018 ALUSrc=1 for ADDI, LDUR, STUR, LSR; Reg2Loc=1 for R-type, 0 for STUR/CBZ; SetFlags only for ADDS, SUBS.
REQ-019 RegWrite for ADDI, ADDS, SUBS, AND, EOR, LSR, LDUR; MemToReg/MemRead only LDUR; MemWrite only STUR; no control output SHALL be X.
REQ-020 Pipeline: ID decode registered into EX, EX into MEM, MEM into WB, each stage with valid bit; controls of invalid stage forced 0.
REQ-021 br_taken = valid & ~stall & ~flush & (B | (CBZ & rd_zero) | (B.LT & (N != V))); id_UncondBr = 1 for B only.
REQ-022 B.LT flag source: if FLAG_FWD=1 and EX valid with SetFlags, use alu_negative/alu_overflow; otherwise flags register.
REQ-023 Flags register loads {alu_negative, alu_zero, alu_overflow, alu_carry} at clock edge when EX valid and SetFlags; otherwise holds.
REQ-024 stall=1: EX receives bubble; MEM, WB advance normally; ID decode output unchanged next cycle if instr held.
REQ-025 flush=1 (with or without stall): EX receives bubble; flush has priority over stall.
REQ-026 Branch instructions (B, CBZ, B.LT) enter EX with all write enables 0.
REQ-027 Undecodable valid instruction: sets illegal (held until reset); enters EX as bubble.
REQ-028 Latency: instruction decoded in cycle n has ex_* at n+1, mem_* at n+2, wb_* at n+3.

Reset
REQ-029 While reset=1 at a clock edge: all stage valid bits, flags, illegal cleared to 0; all registered outputs 0 next cycle.
REQ-030 Reset mid-stream SHALL discard all in-flight instructions; br_taken SHALL be 0 during reset.

Verification
REQ-031 ADDS then LDUR then STUR back-to-back -> ex_ALUOp 010,010,010; wb_RegWrite=1 at cycles 3 and 4, mem_MemWrite=1 at cycle 4, wb_MemToReg=1 only at cycle 4.
REQ-032 SUBS with alu_negative=1, alu_overflow=0, next cycle B.LT, FLAG_FWD=1 -> br_taken=1 same cycle; FLAG_FWD=0 with flags=0 -> br_taken=0.
REQ-033 CBZ with rd_zero=1 and stall=1 -> br_taken=0; stall released -> br_taken=1, ex_* RegWrite chain stays 0.
REQ-034 ADDI with flush=1 -> no wb_RegWrite three cycles later; flags unchanged.
REQ-035 instr=32'h00000000 valid -> illegal=1 next cycle and stays 1 until reset; no write enables asserted.
REQ-036 Reset asserted with three valid instructions in flight -> all mem_/wb_ enables 0, flags=4'b0000 on following cycle.
